// File: rtl/mac_accum.sv
// mac_accum: sequential multiply-accumulate stage fed by the array multiplier.
// Sums exactly TERMS unsigned products {prod_hi, prod_lo} into an ACC_WID-bit
// accumulator. The result is presented under a valid/ready handshake, together
// with a sticky overflow flag.
//
// Build option:
//   MAC_SAT_EN  defined   -> an add that carries out clamps acc_out to all-ones
//               undefined -> adds wrap modulo 2**ACC_WID
// In both modes, ovf records any carry out of the accumulator MSB.
module mac_accum #(
  parameter int DATA_WID  = 4,
  parameter int TERMS     = 8,
  parameter int ACC_GUARD = 4,
  localparam int ACC_WID  = 2*DATA_WID + ACC_GUARD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prod_valid,
  output logic               prod_ready,
  input  logic [DATA_WID-1:0] prod_lo,
  input  logic [DATA_WID-1:0] prod_hi,
  output logic [ACC_WID-1:0] acc_out,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic               ovf,
  output logic               busy
);

  localparam int PROD_WID = 2*DATA_WID;
  localparam int CNT_W    = $clog2(TERMS+1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TERMS-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             take;
  logic             start_ok;
  logic             last_take;
  logic [ACC_WID:0] sum_ext;
  logic             carry;
  logic [ACC_WID-1:0] acc_nxt;

  // A product is consumed only while the FSM is accumulating. prod_ready is
  // decoded from the state register alone, so the handshake never forms a
  // combinational loop with upstream.
  assign take      = prod_valid && prod_ready;
  assign start_ok  = (state == IDLE) && start;
  assign last_take = take && (cnt == LAST_IDX);

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum_ext = {1'b0, acc_out}
                 + {{(ACC_WID+1-PROD_WID){1'b0}}, prod_hi, prod_lo};
  assign carry   = sum_ext[ACC_WID];

`ifdef MAC_SAT_EN
  // Once clamped, every later non-zero add carries again, so the
  // accumulator stays at all-ones without any extra state.
  assign acc_nxt = carry ? '1 : sum_ext[ACC_WID-1:0];
`else
  assign acc_nxt = sum_ext[ACC_WID-1:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so that every
      // flop samples pre-edge values regardless of process ordering.
      state <= state_nxt;
    end
  end

  // Next-state logic. start is looked at only in IDLE, so a start pulse in
  // the cycle that leaves HOLD is dropped.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, which
    // prevents latch inference.
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ACC;
      ACC:     if (last_take) state_nxt = HOLD;
      HOLD:    if (acc_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ACC: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      HOLD: begin
        acc_valid  = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator, sticky overflow and term counter. A start clears all three.
  // A handshake adds one product. Otherwise the values hold, which keeps the
  // last result visible in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
    end else if (start_ok) begin
      acc_out <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
    end else if (take) begin
      acc_out <= acc_nxt;
      ovf     <= ovf | carry;
      cnt     <= cnt + CNT_W'(1);
    end
  end

endmodule
